// File: rtl/elastic_register_pipe_pkg.sv
// Shared helpers for the elastic register pipe: handshake transfer test and a
// constant-foldable ceil(log2) used to size the occupancy counter.
package elastic_register_pipe_pkg;

  function automatic logic xfer(input logic valid, input logic ready);
    return valid & ready;
  endfunction

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/elastic_register_pipe_if.sv
// Producer/consumer handshake bundle for elastic_register_pipe.
// The count signal exists only when ELASTIC_PIPE_COUNT_EN is defined.
interface elastic_register_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    import elastic_register_pipe_pkg::*;

    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef ELASTIC_PIPE_COUNT_EN
    logic [CW-1:0]    count;

    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, count);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, count);
`else
    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid);
`endif
endinterface

// File: rtl/elastic_stage.sv
// One {valid, data} stage of the elastic pipe with load, flush and synchronous reset.
module elastic_stage #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // NOTE: hold values are assigned first so every path writes every output; no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            // Loading implies the current word (if any) moved on; a bubble clears valid, data holds.
            valid_d = up_valid;
            if (up_valid) data_d = up_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/elastic_register_pipe.sv
// DEPTH-stage WIDTH-bit elastic register chain with valid/ready on both ends and flush.
// Define ELASTIC_PIPE_COUNT_EN to add the registered occupancy count output.
module elastic_register_pipe
    import elastic_register_pipe_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    elastic_register_pipe_if.slave pipe_if
);
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   rdy;

    // Ready ripples back from the consumer: a stage can load if empty or if its word leaves.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = pipe_if.out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = ~v[k] | rdy[k+1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_head
            assign up_valid = pipe_if.in_valid;
            assign up_data  = pipe_if.in_data;
        end else begin : g_body
            assign up_valid = v[k-1];
            assign up_data  = d[k-1];
        end

        elastic_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .load     (rdy[k]),
            .up_valid (up_valid),
            .up_data  (up_data),
            .valid    (v[k]),
            .data     (d[k])
        );
    end

    assign pipe_if.in_ready  = rdy[0] & ~flush & ~reset;
    assign pipe_if.out_valid = v[DEPTH-1];
    assign pipe_if.out_data  = d[DEPTH-1];

`ifdef ELASTIC_PIPE_COUNT_EN
    localparam int CW = clog2(DEPTH + 1);

    logic [CW-1:0] count_d, count_q;
    logic          in_xfer, out_xfer;

    assign in_xfer  = xfer(pipe_if.in_valid, pipe_if.in_ready);
    assign out_xfer = xfer(pipe_if.out_valid, pipe_if.out_ready);

    always_comb begin
        count_d = count_q;
        if (flush)                     count_d = '0;
        else if (in_xfer && !out_xfer) count_d = count_q + CW'(1);
        else if (out_xfer && !in_xfer) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign pipe_if.count = count_q;
`endif
endmodule

// File: tb/tb_elastic_register_pipe.sv
// Directed bench for elastic_register_pipe (DEPTH=2, RESET_VALUE=0xFF); count checks
// run only when ELASTIC_PIPE_COUNT_EN is defined.
module tb_elastic_register_pipe;
    logic clk;
    logic reset;
    logic flush;
    int   total;
    int   bad;

    elastic_register_pipe_if #(.WIDTH(8), .DEPTH(2)) bus ();

    elastic_register_pipe #(
        .WIDTH       (8),
        .DEPTH       (2),
        .RESET_VALUE (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .pipe_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        settle();
        check("in_ready_during_reset", 32'(bus.in_ready), 32'h0);
        tick();
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_out_data",  32'(bus.out_data),  32'hFF);
        reset = 1'b0;
        settle();
        check("in_ready_after_reset", 32'(bus.in_ready), 32'h1);
`ifdef ELASTIC_PIPE_COUNT_EN
        check("count_after_reset", 32'(bus.count), 32'h0);
`endif

        // Streaming, consumer always ready: latency 2, data in order
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11;
        tick();
        check("stream_c1_valid", 32'(bus.out_valid), 32'h0);
        bus.in_data = 8'h22;
        tick();
        check("stream_c2_valid", 32'(bus.out_valid), 32'h1);
        check("stream_c2_data",  32'(bus.out_data),  32'h11);
        bus.in_data = 8'h33;
        tick();
        check("stream_c3_valid", 32'(bus.out_valid), 32'h1);
        check("stream_c3_data",  32'(bus.out_data),  32'h22);
        bus.in_valid = 1'b0;
        tick();
        check("stream_c4_valid", 32'(bus.out_valid), 32'h1);
        check("stream_c4_data",  32'(bus.out_data),  32'h33);
        tick();
        check("stream_drained", 32'(bus.out_valid), 32'h0);

        // Backpressure: fill to two words, third refused until consumer takes one
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA1;
        settle();
        check("bp_a1_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_data = 8'hA2;
        settle();
        check("bp_a2_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("bp_full_data", 32'(bus.out_data), 32'hA1);
        bus.in_data = 8'hA3;
        settle();
        check("bp_a3_refused", 32'(bus.in_ready), 32'h0);
        tick();
        check("bp_hold_data", 32'(bus.out_data), 32'hA1);
        bus.out_ready = 1'b1;
        settle();
        check("bp_full_pass_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check("bp_after_pop_data", 32'(bus.out_data), 32'hA2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Stall: output word held stable for four cycles
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", 32'(bus.out_valid), 32'h1);
            check("stall_data",  32'(bus.out_data),  32'hA2);
        end
        bus.out_ready = 1'b1;
        tick();
        check("stall_next_data", 32'(bus.out_data), 32'hA3);
        tick();
        check("stall_no_dup", 32'(bus.out_valid), 32'h0);

        // Flush of a full pipe
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hB1;
        tick();
        bus.in_data = 8'hB2;
        tick();
        check("flush_pre_valid", 32'(bus.out_valid), 32'h1);
        check("flush_pre_data",  32'(bus.out_data),  32'hB1);
        bus.in_valid = 1'b0;
        flush = 1'b1;
        settle();
        check("flush_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        settle();
        check("flush_out_valid", 32'(bus.out_valid), 32'h0);
        check("flush_ready_back", 32'(bus.in_ready), 32'h1);
        tick();
        check("flush_no_ghost1", 32'(bus.out_valid), 32'h0);
        tick();
        check("flush_no_ghost2", 32'(bus.out_valid), 32'h0);

        // Reset mid-stream discards in-flight words
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC1;
        tick();
        bus.in_data = 8'hC2;
        tick();
        check("rst_pre_data", 32'(bus.out_data), 32'hC1);
        reset = 1'b1;
        settle();
        check("rst_in_ready_low", 32'(bus.in_ready), 32'h0);
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'hFF);
        check("rst_in_ready_held", 32'(bus.in_ready), 32'h0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check("rst_discard_valid", 32'(bus.out_valid), 32'h0);
        check("rst_discard_data",  32'(bus.out_data),  32'hFF);

`ifdef ELASTIC_PIPE_COUNT_EN
        // Occupancy: +1 per push, unchanged on push+pop, cleared by flush
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hD1;
        tick();
        check("count_one", 32'(bus.count), 32'h1);
        bus.in_data = 8'hD2;
        tick();
        check("count_two", 32'(bus.count), 32'h2);
        bus.in_data   = 8'hD3;
        bus.out_ready = 1'b1;
        tick();
        check("count_push_pop", 32'(bus.count), 32'h2);
        check("count_push_pop_data", 32'(bus.out_data), 32'hD2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("count_flush", 32'(bus.count), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
